// File: rtl/multi_alarm_clock.sv
// Multi-slot alarm clock: 24-hour timekeeping, NUM_ALARMS alarm slots, registered BCD display
// and a ring/dismiss FSM. Define ALARM_SNOOZE_EN to build the snooze path and SNOOZE state.
module multi_alarm_clock #(
    parameter int TICK_DIV   = 1_666_666,
    parameter int NUM_ALARMS = 4,
    parameter int RING_SECS  = 5,
    parameter int SNOOZE_MIN = 5,
    localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [1:0]            Mode,
    input  logic [SEL_W-1:0]      Sel,
    input  logic [NUM_ALARMS-1:0] AlarmEn,
    input  logic                  minUP,
    input  logic                  hourUP,
    input  logic                  H24,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [3:0]            Hours_MSB,
    output logic [3:0]            Hours_LSB,
    output logic [3:0]            Minutes_MSB,
    output logic [3:0]            Minutes_LSB,
    output logic                  ALARM,
    output logic [SEL_W-1:0]      ALARM_ID,
    output logic                  TICK
);
    localparam int               DIV_W     = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [5:0]       RING_LOAD = 6'(RING_SECS);

    typedef enum logic [1:0] {
        MODE_RUN       = 2'b00,
        MODE_SET_ALARM = 2'b01,
        MODE_ARMED     = 2'b10,
        MODE_SET_TIME  = 2'b11
    } mode_e;

`ifdef ALARM_SNOOZE_EN
    localparam logic [5:0] SNZ_LOAD = 6'(SNOOZE_MIN);
    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_e;
    logic [5:0] snz_cnt_q, snz_cnt_d;
`else
    typedef enum logic {ST_IDLE, ST_RING} state_e;
    localparam int unused_snooze_min = SNOOZE_MIN;
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    function automatic logic [5:0] inc_min(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        tens = 4'(v / 6'd10);
        return {tens, 4'(v - 6'(tens) * 6'd10)};
    endfunction

    mode_e            mode;
    logic             tick;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hour_q, hour_d;
    logic             roll_q, roll_d;
    logic [4:0]       alarm_hour_q [NUM_ALARMS];
    logic [4:0]       alarm_hour_d [NUM_ALARMS];
    logic [5:0]       alarm_min_q  [NUM_ALARMS];
    logic [5:0]       alarm_min_d  [NUM_ALARMS];
    logic [SEL_W-1:0] sel_idx;
    logic             match_hit;
    logic [SEL_W-1:0] match_id;
    state_e           state_q, state_d;
    logic [5:0]       ring_cnt_q, ring_cnt_d;
    logic [SEL_W-1:0] alarm_id_q, alarm_id_d;
    logic [4:0]       disp_hour;
    logic [5:0]       disp_min;
    logic [15:0]      digits_q, digits_d;

    assign mode    = mode_e'(Mode);
    assign tick    = (div_q == DIV_LAST);
    assign sel_idx = (int'(Sel) < NUM_ALARMS) ? Sel : '0;

    // Time of day, divider and alarm slot editing.
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        roll_d      = 1'b0;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;

        if (mode == MODE_SET_TIME) begin
            div_d = '0;
            sec_d = '0;
            if (minUP)  min_d  = inc_min(min_q);
            if (hourUP) hour_d = inc_hour(hour_q);
        end else if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d  = '0;
                roll_d = 1'b1;
                min_d  = inc_min(min_q);
                if (min_q == 6'd59) hour_d = inc_hour(hour_q);
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if (mode == MODE_SET_ALARM) begin
            if (minUP)  alarm_min_d[sel_idx]  = inc_min(alarm_min_q[sel_idx]);
            if (hourUP) alarm_hour_d[sel_idx] = inc_hour(alarm_hour_q[sel_idx]);
        end
    end

    // Scan from the top so the lowest matching slot is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (AlarmEn[i] && alarm_hour_q[i] == hour_q && alarm_min_q[i] == min_q) begin
                match_hit = 1'b1;
                match_id  = SEL_W'(i);
            end
        end
    end

    always_comb begin
        disp_hour = (mode == MODE_SET_ALARM) ? alarm_hour_q[sel_idx] : hour_q;
        disp_min  = (mode == MODE_SET_ALARM) ? alarm_min_q[sel_idx]  : min_q;
        if (!H24) begin
            if (disp_hour == 5'd0)       disp_hour = 5'd12;
            else if (disp_hour > 5'd12)  disp_hour = disp_hour - 5'd12;
        end
        digits_d = {to_bcd({1'b0, disp_hour}), to_bcd(disp_min)};
    end

    // roll_q marks the cycle right after seconds wrapped; it drives both alarm matching and snooze.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        alarm_id_d = alarm_id_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        if (mode != MODE_ARMED) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (roll_q && match_hit) begin
                        state_d    = ST_RING;
                        ring_cnt_d = RING_LOAD;
                        alarm_id_d = match_id;
                    end
                end
                ST_RING: begin
                    if (dismiss) begin
                        state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_d   = ST_SNOOZE;
                        snz_cnt_d = SNZ_LOAD;
`endif
                    end else if (tick) begin
                        if (ring_cnt_q == 6'd1) state_d    = ST_IDLE;
                        else                    ring_cnt_d = ring_cnt_q - 6'd1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (dismiss) begin
                        state_d = ST_IDLE;
                    end else if (roll_q) begin
                        if (snz_cnt_q == 6'd1) begin
                            state_d    = ST_RING;
                            ring_cnt_d = RING_LOAD;
                        end else begin
                            snz_cnt_d = snz_cnt_q - 6'd1;
                        end
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            div_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            roll_q     <= 1'b0;
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            alarm_id_q <= '0;
            digits_q   <= '0;
            // NOTE: the alarm slots are plain flops, not a RAM, so they take the async reset to 00:00.
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_hour_q[i] <= '0;
                alarm_min_q[i]  <= '0;
            end
        end else begin
            div_q        <= div_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            roll_q       <= roll_d;
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            alarm_id_q   <= alarm_id_d;
            digits_q     <= digits_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) snz_cnt_q <= '0;
        else      snz_cnt_q <= snz_cnt_d;
    end
`endif

    assign ALARM       = (state_q == ST_RING);
    assign ALARM_ID    = alarm_id_q;
    assign TICK        = tick;
    assign Hours_MSB   = digits_q[15:12];
    assign Hours_LSB   = digits_q[11:8];
    assign Minutes_MSB = digits_q[7:4];
    assign Minutes_LSB = digits_q[3:0];

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: a seconds-of-day reference model compared every cycle,
// directed scenarios with literal expectations, then randomized alarm/time/button traffic.
module tb_multi_alarm_clock;
    localparam int TD = 4;
    localparam int NA = 4;
    localparam int RS = 5;
    localparam int SM = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [1:0]    Mode = 2'b00;
    logic [1:0]    Sel = 2'd0;
    logic [NA-1:0] AlarmEn = '0;
    logic          minUP = 1'b0;
    logic          hourUP = 1'b0;
    logic          H24 = 1'b0;
    logic          snooze = 1'b0;
    logic          dismiss = 1'b0;
    logic [3:0]    Hours_MSB, Hours_LSB, Minutes_MSB, Minutes_LSB;
    logic          ALARM;
    logic [1:0]    ALARM_ID;
    logic          TICK;

    multi_alarm_clock #(
        .TICK_DIV(TD), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)
    ) dut (
        .CLK(clk), .CLR(clr), .Mode(Mode), .Sel(Sel), .AlarmEn(AlarmEn),
        .minUP(minUP), .hourUP(hourUP), .H24(H24), .snooze(snooze), .dismiss(dismiss),
        .Hours_MSB(Hours_MSB), .Hours_LSB(Hours_LSB),
        .Minutes_MSB(Minutes_MSB), .Minutes_LSB(Minutes_LSB),
        .ALARM(ALARM), .ALARM_ID(ALARM_ID), .TICK(TICK)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: time as seconds of day, alarms as minutes of day, ringing as ticks left.
    int          m_div, m_tod, m_ring_left, m_snz_left, m_id;
    int          m_alarm [NA];
    bit          m_roll;
    logic [15:0] m_disp;

    always @(posedge clk or negedge clr) begin
        int h, m, s, dh, dm, slot, ah, am;
        bit tk;
        if (!clr) begin
            m_div = 0; m_tod = 0; m_ring_left = 0; m_snz_left = 0; m_id = 0;
            m_roll = 1'b0; m_disp = '0;
            for (int k = 0; k < NA; k++) m_alarm[k] = 0;
        end else begin
            tk   = (m_div == TD - 1);
            h    = m_tod / 3600;
            m    = (m_tod / 60) % 60;
            s    = m_tod % 60;
            slot = (int'(Sel) < NA) ? int'(Sel) : 0;

            dh = (Mode == 2'b01) ? m_alarm[slot] / 60 : h;
            dm = (Mode == 2'b01) ? m_alarm[slot] % 60 : m;
            if (!H24) dh = (dh == 0) ? 12 : ((dh > 12) ? dh - 12 : dh);
            m_disp = {4'(dh / 10), 4'(dh % 10), 4'(dm / 10), 4'(dm % 10)};

            if (Mode != 2'b10) begin
                m_ring_left = 0;
                m_snz_left  = 0;
            end else if (m_ring_left > 0) begin
                if (dismiss) m_ring_left = 0;
                else if (SNZ && snooze) begin
                    m_ring_left = 0;
                    m_snz_left  = SM;
                end else if (tk) m_ring_left--;
            end else if (m_snz_left > 0) begin
                if (dismiss) m_snz_left = 0;
                else if (m_roll) begin
                    m_snz_left--;
                    if (m_snz_left == 0) m_ring_left = RS;
                end
            end else if (m_roll) begin
                for (int k = NA - 1; k >= 0; k--) begin
                    if (AlarmEn[k] && m_alarm[k] == h * 60 + m) begin
                        m_id        = k;
                        m_ring_left = RS;
                    end
                end
            end

            m_roll = tk && (Mode != 2'b11) && (s == 59);

            if (Mode == 2'b11) begin
                h = (h + int'(hourUP)) % 24;
                m = (m + int'(minUP)) % 60;
                m_tod = h * 3600 + m * 60;
            end else if (tk) begin
                m_tod = (m_tod + 1) % 86400;
            end

            if (Mode == 2'b01) begin
                ah = (m_alarm[slot] / 60 + int'(hourUP)) % 24;
                am = (m_alarm[slot] % 60 + int'(minUP)) % 60;
                m_alarm[slot] = ah * 60 + am;
            end

            m_div = (Mode == 2'b11) ? 0 : (m_div + 1) % TD;
        end
    end

    always @(negedge clk) begin
        check("tick",     32'(TICK),     32'(m_div == TD - 1));
        check("alarm",    32'(ALARM),    32'(m_ring_left > 0));
        check("alarm_id", 32'(ALARM_ID), 32'(m_id));
        check("digits",   {16'h0, Hours_MSB, Hours_LSB, Minutes_MSB, Minutes_LSB}, {16'h0, m_disp});
    end

    function automatic logic [31:0] digits();
        return {16'h0, Hours_MSB, Hours_LSB, Minutes_MSB, Minutes_LSB};
    endfunction

    task automatic wait_ticks(input int n);
        while (n > 0) begin
            @(negedge clk);
            if (m_div == TD - 1) n--;
        end
    endtask

    task automatic pulse_up(input bit h, input bit m);
        hourUP = h; minUP = m;
        @(negedge clk);
        hourUP = 1'b0; minUP = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_time(input int h, input int m);
        int nh, nm;
        Mode = 2'b11;
        nh = (h - m_tod / 3600 + 24) % 24;
        nm = (m - (m_tod / 60) % 60 + 60) % 60;
        repeat (nh) pulse_up(1'b1, 1'b0);
        repeat (nm) pulse_up(1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic ring_at_0730();
        set_time(7, 29);
        Mode = 2'b10;
        wait_ticks(60);
        @(negedge clk);
        check("alarm_lat1", 32'(ALARM), 32'd0);
        @(negedge clk);
        check("alarm_rise", 32'(ALARM), 32'd1);
        check("alarm_id1",  32'(ALARM_ID), 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt, k;
        #2 clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_digits", digits(), 32'h0);
        check("rst_alarm",  32'(ALARM), 32'd0);
        check("rst_tick",   32'(TICK), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        check("first_disp_12h", digits(), 32'h1200);

        wait_ticks(3600);
        repeat (2) @(negedge clk);
        check("model_tod_1h", 32'(m_tod), 32'd3600);
        check("disp_0100",    digits(), 32'h0100);

        set_time(23, 59);
        Mode = 2'b00;
        wait_ticks(59);
        @(negedge clk);
        check("model_tod_235959", 32'(m_tod), 32'd86399);
        wait_ticks(1);
        repeat (2) @(negedge clk);
        check("model_tod_wrap", 32'(m_tod), 32'd0);
        check("disp_midnight_12h", digits(), 32'h1200);
        H24 = 1'b1;
        repeat (2) @(negedge clk);
        check("disp_midnight_24h", digits(), 32'h0000);

        Mode = 2'b01; Sel = 2'd2;
        repeat (7)  pulse_up(1'b1, 1'b0);
        repeat (30) pulse_up(1'b0, 1'b1);
        @(negedge clk);
        check("slot2_disp", digits(), 32'h0730);
        check("model_slot2", 32'(m_alarm[2]), 32'd450);
        Sel = 2'd0;
        repeat (2) @(negedge clk);
        check("slot0_disp", digits(), 32'h0000);
        Sel = 2'd1;
        repeat (7)  pulse_up(1'b1, 1'b0);
        repeat (30) pulse_up(1'b0, 1'b1);
        AlarmEn = 4'b0110;

        ring_at_0730();
        wait_ticks(RS);
        check("ring_hold", 32'(ALARM), 32'd1);
        @(negedge clk);
        check("ring_timeout", 32'(ALARM), 32'd0);

        ring_at_0730();
        wait_ticks(1);
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        if (SNZ) begin
            check("snoozed", 32'(ALARM), 32'd0);
            wait_ticks(119);
            @(negedge clk);
            check("snooze_wait", 32'(ALARM), 32'd0);
            check("model_tod_0732", 32'(m_tod), 32'd27120);
            @(negedge clk);
            check("resnooze_ring", 32'(ALARM), 32'd1);
            check("resnooze_id",   32'(ALARM_ID), 32'd1);
            snooze = 1'b1; dismiss = 1'b1;
            @(negedge clk);
            snooze = 1'b0; dismiss = 1'b0;
            check("dismiss_wins", 32'(ALARM), 32'd0);
        end else begin
            check("snooze_ignored", 32'(ALARM), 32'd1);
            wait_ticks(RS - 1);
            check("ring_full", 32'(ALARM), 32'd1);
            @(negedge clk);
            check("ring_full_end", 32'(ALARM), 32'd0);
        end

        ring_at_0730();
        Mode = 2'b00;
        @(negedge clk);
        check("mode_exit", 32'(ALARM), 32'd0);

        ring_at_0730();
        #3 clr = 1'b0;
        #1;
        check("async_clr_alarm", 32'(ALARM), 32'd0);
        check("async_clr_id",    32'(ALARM_ID), 32'd0);
        check("async_clr_disp",  digits(), 32'h0);
        check("async_clr_tick",  32'(TICK), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        for (int it = 0; it < 25; it++) begin
            Mode = 2'b01;
            repeat (3) begin
                Sel = 2'($urandom_range(0, NA - 1));
                repeat ($urandom_range(0, 8)) pulse_up(1'($urandom), 1'($urandom));
            end
            AlarmEn = 4'($urandom);
            H24     = 1'($urandom);
            k       = $urandom_range(0, NA - 1);
            tgt     = (m_alarm[k] * 60 - 60 + 86400) % 86400;
            set_time(tgt / 3600, (tgt / 60) % 60);
            Mode = 2'b10;
            repeat (700) begin
                @(negedge clk);
                snooze  = ($urandom % 30) == 0;
                dismiss = ($urandom % 60) == 0;
                minUP   = ($urandom % 50) == 0;
                hourUP  = ($urandom % 50) == 0;
                if (($urandom % 100) == 0) H24  = ~H24;
                if (($urandom % 50) == 0)  Sel  = 2'($urandom);
                if (($urandom % 300) == 0) Mode = 2'($urandom);
                else if (($urandom % 40) == 0) Mode = 2'b10;
            end
            snooze = 1'b0; dismiss = 1'b0; minUP = 1'b0; hourUP = 1'b0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
